// File: rtl/count_display_driver.sv
// count_display_driver: samples an 8-bit counter value on a strobe, converts it to BCD with a
// sequential double-dabble engine and scans the result onto a 4-digit common-anode 7-seg display.
// Hex mode shows the raw byte as two hex digits plus an 'h' marker.
module count_display_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  input  logic        upd,
  input  logic        hex_mode,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegH     = 7'b0001011;

  typedef enum logic [1:0] {StIdle, StConv, StLatch} state_e;

  state_e      state;
  logic [7:0]  shreg;     // bits still to be shifted into the BCD scratch
  logic [7:0]  cap_val;   // untouched copy of the sampled byte for hex display
  logic [11:0] scratch;
  logic [2:0]  bit_cnt;
  logic        mode;
  logic [7:0]  disp_val;
  logic        disp_hex;
  logic [11:0] adj;

  logic [PreW-1:0] pre;
  logic [1:0]      idx;

  logic [3:0] nib;
  logic       blank;
  logic       show_h;

  // Add-3 correction on every scratch nibble >= 5 before the next shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Converter FSM: launch on strobe, eight shift cycles, then latch into display registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      shreg    <= '0;
      cap_val  <= '0;
      scratch  <= '0;
      bit_cnt  <= '0;
      mode     <= 1'b0;
      busy     <= 1'b0;
      bcd      <= '0;
      disp_val <= '0;
      disp_hex <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (upd) begin
            shreg   <= value;
            cap_val <= value;
            mode    <= hex_mode;
            scratch <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= StConv;
          end
        end
        StConv: begin
          {scratch, shreg} <= {adj[10:0], shreg, 1'b0};
          bit_cnt          <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= StLatch;
        end
        StLatch: begin
          bcd      <= scratch;
          disp_val <= cap_val;
          disp_hex <= mode;
          busy     <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Free-running scan prescaler; each wrap advances the digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PreMax) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Select digit content for the active slot, with leading-zero blanking in decimal mode.
  always_comb begin
    nib    = 4'd0;
    blank  = 1'b0;
    show_h = 1'b0;
    if (disp_hex) begin
      unique case (idx)
        2'd0: nib = disp_val[3:0];
        2'd1: nib = disp_val[7:4];
        2'd2: blank = 1'b1;
        2'd3: show_h = 1'b1;
        default: blank = 1'b1;
      endcase
    end else begin
      unique case (idx)
        2'd0: nib = bcd[3:0];
        2'd1: begin
          nib   = bcd[7:4];
          blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
        end
        2'd2: begin
          nib   = bcd[11:8];
          blank = (bcd[11:8] == 4'd0);
        end
        2'd3: blank = 1'b1;
        default: blank = 1'b1;
      endcase
    end
  end

  // Active-low segment decode {g,f,e,d,c,b,a}.
  always_comb begin
    seg = SegBlank;
    if (show_h) begin
      seg = SegH;
    end else if (!blank) begin
      unique case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        4'hF: seg = 7'b0001110;
        default: seg = SegBlank;
      endcase
    end
  end

  assign an = ~(4'b0001 << idx);
  assign dp = 1'b1;

endmodule
